// File: rtl/rvv_alu_sequencer.sv
// Sequences one vector ALU pass: latches the request, feeds per-lane ALU writes into
// the destination register image, guards the pass with a watchdog and reports done/error.

module rvv_alu_seq_lane (
  input  logic        active,
  input  logic        res,
  input  logic [9:0]  regi,
  input  logic [10:0] elems,
  output logic        acc
);
  // Writes past the body (tail) are dropped here so they never reach the merge.
  assign acc = active & res & ({1'b0, regi} < elems);
endmodule

module rvv_alu_sequencer #(
  parameter int VLEN     = 128,
  parameter int NB_LANES = 1
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      start,
  input  logic [2:0]                vsew,
  input  logic [10:0]               vl,
  input  logic [VLEN-1:0]           vd_old,
  output logic                      busy,
  output logic                      done,
  output logic                      error,
  output logic [VLEN-1:0]           result,
  output logic                      alu_run,
  output logic [10:0]               alu_remaining,
  input  logic [(64<<NB_LANES)-1:0] alu_vd,
  input  logic [(10<<NB_LANES)-1:0] alu_regi,
  input  logic [(1<<NB_LANES)-1:0]  alu_res,
  input  logic                      alu_done
);
  localparam int LANES  = 1 << NB_LANES;
  localparam int NBYTES = VLEN / 8;

  typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, FIN} state_t;

  state_t          state;
  logic [2:0]      vsew_q;
  logic [10:0]     vl_q;
  logic [VLEN-1:0] vd_q;
  logic [10:0]     elems;
  logic [10:0]     elems_calc;
  logic [15:0]     wd;
  logic [15:0]     wd_limit;
  logic [LANES-1:0] acc;
  logic [3:0]      acc_cnt;
  logic [10:0]     rem_nxt;
  logic [VLEN-1:0] result_nxt;
  logic            in_run;

  assign in_run     = (state == RUN) || (state == DRAIN);
  assign elems_calc = ({21'b0, vl_q} < (32'(NBYTES) >> vsew_q[1:0])) ? vl_q
                                                                      : 11'(32'(NBYTES) >> vsew_q[1:0]);
  assign wd_limit   = {2'b0, elems, 3'b0} + 16'd16;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    rvv_alu_seq_lane u_lane (
      .active (in_run),
      .res    (alu_res[l]),
      .regi   (alu_regi[l*10 +: 10]),
      .elems  (elems),
      .acc    (acc[l])
    );
  end

  always_comb begin
    acc_cnt = 4'd0;
    for (int l = 0; l < LANES; l++) acc_cnt = acc_cnt + {3'b0, acc[l]};
    rem_nxt = (alu_remaining > {7'b0, acc_cnt}) ? alu_remaining - {7'b0, acc_cnt} : 11'd0;
  end

  // Byte-granular merge; later (higher) lanes overwrite earlier ones on index collisions.
  always_comb begin
    result_nxt = result;
    for (int l = 0; l < LANES; l++) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (acc[l] && ((32'(b) >> vsew_q[1:0]) == {22'b0, alu_regi[l*10 +: 10]}))
          result_nxt[b*8 +: 8] = alu_vd[l*64 + (b & ((1 << vsew_q[1:0]) - 1))*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= IDLE;
      vsew_q        <= '0;
      vl_q          <= '0;
      vd_q          <= '0;
      elems         <= '0;
      wd            <= '0;
      result        <= '0;
      alu_remaining <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      alu_run       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          vsew_q <= vsew;
          vl_q   <= vl;
          vd_q   <= vd_old;
          busy   <= 1'b1;
          state  <= LOAD;
        end
        LOAD: begin
          result <= vd_q;
          elems  <= vsew_q[2] ? 11'd0 : elems_calc;
          if (vsew_q[2]) begin
            error <= 1'b1;
            done  <= 1'b1;
            state <= FIN;
          end else if (elems_calc == 11'd0) begin
            done  <= 1'b1;
            state <= FIN;
          end else begin
            alu_remaining <= elems_calc;
            wd            <= '0;
            alu_run       <= 1'b1;
            state         <= RUN;
          end
        end
        RUN: begin
          result        <= result_nxt;
          alu_remaining <= rem_nxt;
          wd            <= wd + 16'd1;
          if (alu_done) begin
            state <= DRAIN;
          end else if (wd == wd_limit - 16'd1) begin
            error   <= 1'b1;
            done    <= 1'b1;
            alu_run <= 1'b0;
            state   <= FIN;
          end
        end
        DRAIN: begin
          result        <= result_nxt;
          alu_remaining <= rem_nxt;
          done          <= 1'b1;
          alu_run       <= 1'b0;
          state         <= FIN;
        end
        FIN: begin
          done  <= 1'b0;
          error <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/rvv_alu_sequencer.md
RVV_ALU_SEQUENCER -- requirements
Module: rvv_alu_sequencer

Interface
REQ-001 SHALL have parameter VLEN, default 128, vector register width in bits.
REQ-002 SHALL have parameter NB_LANES, default 1, log2 of the ALU lane count, range 0..3.
REQ-003 SHALL have port clk, input, 1 bit, the single clock.
REQ-004 SHALL have port resetn, input, 1 bit, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1 bit, one-cycle request; sampled only in IDLE.
REQ-006 SHALL have port vsew, input, 3 bits, element width code; SEW = 8<<vsew.
REQ-007 SHALL have port vl, input, 11 bits, requested element count.
REQ-008 SHALL have port vd_old, input, VLEN bits, prior destination contents.
REQ-009 SHALL have port busy, output, 1 bit, high from accept to done.
REQ-010 SHALL have port done, output, 1 bit, one-cycle completion pulse.
REQ-011 SHALL have port error, output, 1 bit, valid with done: illegal vsew or watchdog abort.
REQ-012 SHALL have port result, output, VLEN bits, assembled destination register.
REQ-013 SHALL have port alu_run, output, 1 bit, run to the ALU wrapper.
REQ-014 SHALL have port alu_remaining, output, 11 bits, elements not yet produced.
REQ-015 SHALL have ports alu_vd (64<<NB_LANES bits), alu_regi (10<<NB_LANES bits) and alu_res (1<<NB_LANES bits), all inputs: per-lane result, element index and lane-active flags.
REQ-016 SHALL have port alu_done, input, 1 bit, ALU end-of-pass flag.

Function
REQ-017 SHALL implement states IDLE, LOAD, RUN, DRAIN and FIN, encoded in 3 bits.
REQ-018 In IDLE, start=1 SHALL latch vsew, vl and vd_old and go to LOAD; start is ignored in every other state.
REQ-019 LOAD SHALL compute elems = min(vl, VLEN>>(vsew+3)) in one cycle; result is loaded with vd_old.
REQ-020 vsew > 3 in LOAD SHALL set error and go to FIN.
REQ-021 elems = 0 in LOAD SHALL go to FIN with error=0, result = vd_old, and alu_run never asserted.
REQ-022 Otherwise LOAD SHALL go to RUN with alu_remaining = elems.
REQ-023 alu_run SHALL be 1 exactly in RUN and DRAIN.
REQ-024 In RUN and DRAIN, each cycle and for each lane i with alu_res[i]=1 and alu_regi[i] < elems, the low SEW bits of alu_vd lane i SHALL be written to result element alu_regi[i].
REQ-025 Active lanes whose alu_regi[i] >= elems SHALL be ignored.
REQ-026 Each cycle in RUN and DRAIN, alu_remaining SHALL decrease by popcount of the accepted lanes, saturating at 0.
REQ-027 Elements at or above elems (tail) SHALL keep their vd_old value.
REQ-028 alu_done=1 in RUN SHALL go to DRAIN; DRAIN SHALL last exactly one cycle, still accepting writes, then go to FIN.
REQ-029 FIN SHALL pulse done for one cycle, then return to IDLE.
REQ-030 result SHALL hold its value in IDLE until the next accepted start.
REQ-031 A watchdog counter SHALL clear on entry to RUN and increment each RUN cycle.
REQ-032 Reaching (elems<<3)+16 cycles SHALL abort to FIN with error=1.
REQ-033 busy SHALL be 1 in LOAD, RUN, DRAIN and FIN; it drops in the cycle after done.
REQ-034 Two lanes writing the same index in one cycle SHALL resolve to the higher lane number.

Reset
REQ-035 resetn=0 SHALL immediately force state IDLE, and result, alu_remaining, watchdog, busy, done, error and alu_run to 0, including mid-RUN.
REQ-036 The first start SHALL be accepted on the first rising edge after resetn deasserts.

Verification
REQ-037 vsew=0, vl=16, VLEN=128, NB_LANES=1, ALU model writing element k = k+1 -> done after 8 RUN cycles plus DRAIN; result bytes 0x01..0x10; error=0.
REQ-038 vsew=2, vl=2, vd_old all 0xFF -> words 0 and 1 hold ALU data, words 2 and 3 = 0xFFFFFFFF.
REQ-039 vl=0 -> done two cycles after start, result = vd_old, alu_run never high.
REQ-040 vsew=5 -> done with error=1, alu_run never high.
REQ-041 ALU model never asserting res or done with vl=4, vsew=0 -> abort after 48 RUN cycles, error=1.
REQ-042 resetn pulled low mid-RUN -> all outputs 0 asynchronously; a new start after release completes normally.
